check_code: RTL
===============

CHECK_CODE -- requirements
Module: check_code

Interface
REQ-001 The block SHALL have parameter LOCK_CYCLES, default 16, giving the lockout duration in CLK cycles; it is used only when LOCKOUT_EN is defined.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port GO, input, 1 bit: starts one code-entry attempt.
REQ-005 The block SHALL have port BUTTON, input, 4 bits: the key value, valid while BPRESS=1.
REQ-006 The block SHALL have port BPRESS, input, 1 bit: a one-cycle pulse marking one key press.
REQ-007 The block SHALL have port ENTER_BUTTON, input, 4 bits: the key value that terminates entry.
REQ-008 The block SHALL have port CODE, input, 24 bits: the stored user code, right-aligned, with the newest digit at [3:0] and one digit per nibble.
REQ-009 The block SHALL have port LENGTH, input, 3 bits: the number of valid digits in CODE.
REQ-010 The block SHALL have port DONE, output, 1 bit: a one-cycle pulse marking the end of an attempt.
REQ-011 The block SHALL have port SUCCESS, output, 1 bit: high together with DONE when the attempt matched.
REQ-012 The block SHALL have port LOCKED, output, 1 bit: high during lockout; it exists only when LOCKOUT_EN is defined.

Function
REQ-013 The FSM SHALL have states START, BUFFER, ENTER, WAIT, CORRECT, INCORRECT, plus LOCKOUT when LOCKOUT_EN is defined.
REQ-014 In START, GO=1 SHALL clear the entry register and digit count, then go to BUFFER; GO=0 stays in START; BPRESS in START SHALL be ignored.
REQ-015 BUFFER SHALL last exactly one cycle, then go to ENTER; key presses in BUFFER SHALL be ignored.
REQ-016 In ENTER, a press of BUTTON≠ENTER_BUTTON with BUTTON in 1..6 and count<6 SHALL shift the entry register left 4 bits, load BUTTON into [3:0], and increment count.
REQ-017 In ENTER, a press of BUTTON≠ENTER_BUTTON with BUTTON outside 1..6, or with count=6, SHALL go to WAIT without changing the register.
REQ-018 In ENTER, a press of ENTER_BUTTON SHALL go to CORRECT only if LENGTH is in 4..6, count=LENGTH, and the low 4×LENGTH bits of the entry register equal the same bits of CODE; otherwise it goes to INCORRECT.
REQ-019 In WAIT, all presses SHALL be ignored except ENTER_BUTTON, which goes to INCORRECT.
REQ-020 CORRECT SHALL assert DONE=1 and SUCCESS=1; INCORRECT SHALL assert DONE=1 and SUCCESS=0; each lasts one cycle, then returns to START, or to LOCKOUT per REQ-026.
REQ-021 DONE SHALL rise in the cycle after the cycle in which the ENTER_BUTTON press was sampled.
REQ-022 DONE and SUCCESS SHALL be decoded directly from state bits, with no combinational path from the inputs.
REQ-023 GO asserted outside START SHALL be ignored; CODE and LENGTH SHALL be sampled only when ENTER_BUTTON is pressed.
REQ-024 A press with count=0 followed by ENTER_BUTTON SHALL result in INCORRECT.

Reset
REQ-025 With RST=1 at a clock edge, the block SHALL, from any state including mid-entry or LOCKOUT:
- go to START;
- clear the entry register, count, fail counter and lock timer;
- drive DONE=0, SUCCESS=0, LOCKED=0 from the next cycle.

Configuration
REQ-026 When macro CHECK_CODE_LOCKOUT_EN is defined, the block SHALL behave as follows:
- a 2-bit fail counter increments on INCORRECT;
- the counter clears on CORRECT;
- on the third consecutive INCORRECT, the FSM goes to LOCKOUT instead of START and clears the counter;
- LOCKOUT holds LOCKED=1 for exactly LOCK_CYCLES cycles, ignores GO and BPRESS, then goes to START.
REQ-027 When CHECK_CODE_LOCKOUT_EN is undefined, the LOCKED port, fail counter, lock timer and LOCKOUT state SHALL be absent, and unlimited attempts are allowed.

Structure
REQ-028 A shared package SHALL hold:
- the state encodings;
- MIN_LEN=4, MAX_LEN=6;
- KEY_MIN=1, KEY_MAX=6;
- the code width of 24.
REQ-029 The entry register SHALL be one sub-module, entry_shift_reg, with ports clk, rst, clear, shift, button, entry[23:0], count[2:0]; comparison masking and the FSM stay in check_code.

Verification
REQ-030 With CODE=24'h001234, LENGTH=4, ENTER_BUTTON=4'hF: GO, then presses 1,2,3,4,F SHALL give DONE=1 and SUCCESS=1 for one cycle, one cycle after the F press.
REQ-031 Same setup, presses 1,2,3,5,F SHALL give DONE=1, SUCCESS=0; presses 1,2,3,4,4,F (count 5≠4) SHALL give DONE=1, SUCCESS=0.
REQ-032 Presses 7,1,2,3,4,F (invalid key) SHALL give DONE=1, SUCCESS=0, with no DONE before the F press.
REQ-033 With CODE=24'h123456, LENGTH=6: presses 1..6,F SHALL give SUCCESS=1; presses 1..6,1,F SHALL give INCORRECT via WAIT.
REQ-034 RST asserted after two digits SHALL return the FSM to START; a following GO plus full correct entry SHALL give SUCCESS=1, and a press issued during BUFFER SHALL be ignored.
REQ-035 With CHECK_CODE_LOCKOUT_EN defined, three wrong attempts SHALL set LOCKED=1 for 16 cycles, with GO ignored throughout; a correct entry afterwards SHALL give SUCCESS=1.

Source files
------------

// File: rtl/check_code_pkg.sv
// Shared constants and FSM state encoding for the check_code keypad checker.
// CHECK_CODE_LOCKOUT_EN adds the LOCKOUT state used after repeated failures.
package check_code_pkg;

   localparam int CODE_W  = 24;
   localparam int DIGIT_W = 4;
   localparam int MIN_LEN = 4;
   localparam int MAX_LEN = 6;
   localparam int KEY_MIN = 1;
   localparam int KEY_MAX = 6;

   // Bit 2 marks a result state; bit 1 inside a result state marks success.
   // DONE and SUCCESS are decoded from these bits alone.
   typedef enum logic [2:0] {
      START     = 3'b000,
      BUFFER    = 3'b001,
      ENTER     = 3'b010,
      WAIT      = 3'b011,
      INCORRECT = 3'b100,
`ifdef CHECK_CODE_LOCKOUT_EN
      LOCKOUT   = 3'b101,
`endif
      CORRECT   = 3'b110
   } state_t;

   // Mask covering the low len digits of a code word.
   function automatic logic [CODE_W-1:0] len_mask(input logic [2:0] len);
      logic [CODE_W-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < int'(len)) m[i*DIGIT_W +: DIGIT_W] = '1;
      end
      return m;
   endfunction

endpackage

// File: rtl/check_code_entry_shift_reg.sv
// Digit entry register for check_code: shifts one key value in per accepted
// press (newest digit at [3:0]) and counts the digits held.
module entry_shift_reg
   import check_code_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               shift,
   input  logic [DIGIT_W-1:0] button,
   output logic [CODE_W-1:0]  entry,
   output logic [2:0]         count
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         entry <= '0;
         count <= '0;
      end else if (shift) begin
         entry <= {entry[CODE_W-DIGIT_W-1:0], button};
         count <= count + 3'd1;
      end
   end

endmodule

// File: rtl/check_code.sv
// Keypad code checker: collects digits after GO and compares them to CODE on
// ENTER_BUTTON. CHECK_CODE_LOCKOUT_EN adds a fail counter and timed LOCKOUT.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// START     | idle, waiting for GO
// BUFFER    | one settling cycle, presses ignored
// ENTER     | accepting digit presses
// WAIT      | bad key seen, only ENTER_BUTTON (-> INCORRECT) matters
// CORRECT   | DONE=1 SUCCESS=1 for one cycle
// INCORRECT | DONE=1 SUCCESS=0 for one cycle
// LOCKOUT   | LOCKED=1 for LOCK_CYCLES cycles, all input ignored
module check_code
   import check_code_pkg::*;
#(
   parameter int LOCK_CYCLES = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               GO,
   input  logic [DIGIT_W-1:0] BUTTON,
   input  logic               BPRESS,
   input  logic [DIGIT_W-1:0] ENTER_BUTTON,
   input  logic [CODE_W-1:0]  CODE,
   input  logic [2:0]         LENGTH,
   output logic               DONE,
   output logic               SUCCESS
`ifdef CHECK_CODE_LOCKOUT_EN
  ,output logic               LOCKED
`endif
);

   if (LOCK_CYCLES < 1) begin : g_lock_chk
      $error("check_code: LOCK_CYCLES must be at least 1");
   end

   state_t            state;
   state_t            state_nxt;
   logic [CODE_W-1:0] entry;
   logic [2:0]        count;
   logic              clear;
   logic              shift;
   logic              enter_hit;
   logic              key_ok;
   logic              len_ok;
   logic              code_ok;

   entry_shift_reg u_entry (
      .clk    (CLK),
      .rst    (RST),
      .clear  (clear),
      .shift  (shift),
      .button (BUTTON),
      .entry  (entry),
      .count  (count)
   );

   assign enter_hit = BPRESS && (BUTTON == ENTER_BUTTON);
   assign key_ok    = (BUTTON >= 4'(KEY_MIN)) && (BUTTON <= 4'(KEY_MAX))
                      && (count < 3'(MAX_LEN));
   assign len_ok    = (LENGTH >= 3'(MIN_LEN)) && (LENGTH <= 3'(MAX_LEN))
                      && (count == LENGTH);
   assign code_ok   = ((entry ^ CODE) & len_mask(LENGTH)) == '0;

`ifdef CHECK_CODE_LOCKOUT_EN
   localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   logic [1:0]        fail_cnt;
   logic [LOCK_W-1:0] lock_tmr;
   logic              lock_go;

   // Two earlier consecutive failures make this INCORRECT the third.
   assign lock_go = (fail_cnt == 2'd2);

   always_ff @(posedge CLK) begin
      if (RST) begin
         fail_cnt <= '0;
         lock_tmr <= '0;
      end else begin
         case (state)
            CORRECT: fail_cnt <= '0;
            INCORRECT: begin
               if (lock_go) begin
                  fail_cnt <= '0;
                  lock_tmr <= LOCK_W'(LOCK_CYCLES - 1);
               end else begin
                  fail_cnt <= fail_cnt + 2'd1;
               end
            end
            LOCKOUT: begin
               if (lock_tmr != '0) lock_tmr <= lock_tmr - LOCK_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign LOCKED = (state == LOCKOUT);
`endif

   always_ff @(posedge CLK) begin
      if (RST) state <= START;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      shift     = 1'b0;
      case (state)
         START: begin
            if (GO) begin
               clear     = 1'b1;
               state_nxt = BUFFER;
            end
         end
         BUFFER: state_nxt = ENTER;
         ENTER: begin
            if (enter_hit) begin
               state_nxt = (len_ok && code_ok) ? CORRECT : INCORRECT;
            end else if (BPRESS) begin
               if (key_ok) shift     = 1'b1;
               else        state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (enter_hit) state_nxt = INCORRECT;
         end
         CORRECT: state_nxt = START;
`ifdef CHECK_CODE_LOCKOUT_EN
         INCORRECT: state_nxt = lock_go ? LOCKOUT : START;
         LOCKOUT: begin
            if (lock_tmr == '0) state_nxt = START;
         end
`else
         INCORRECT: state_nxt = START;
`endif
         default: state_nxt = START;
      endcase
   end

   assign DONE    = state[2] & ~state[0];
   assign SUCCESS = state[2] & state[1];

endmodule
